// File: rtl/calc_port_responder.sv
// calc_port_responder
//   Device-side responder for one port of the calc request/response protocol.
//   A request takes two cycles: the command with operand 1, then operand 2.
//   The block computes add, subtract, shift left or shift right and presents a
//   one-cycle response code with result data LATENCY edges after the operand-2
//   capture edge.
//
// Parameters
//   LATENCY      edges from the operand-2 capture edge to the visible response (1..15)
//
// Ports
//   c_clk        clock, rising edge
//   reset        asynchronous, active-low reset
//   req_cmd_in   [0:3]  command: 0 none, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//   req_data_in  [0:31] operand bus (bit 0 is the MSB)
//   out_resp     [0:1]  response: 0 none, 1 success, 2 overflow/underflow/invalid
//   out_data     [0:31] result, nonzero only while out_resp is 1
//   busy                high whenever the block is not idle
//   err_count    [0:7]  saturating count of error responses (only with CALC_ERR_COUNT_EN)
//
// Optional feature macro: CALC_ERR_COUNT_EN
module calc_port_responder #(
  parameter int LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
`ifdef CALC_ERR_COUNT_EN
  ,
  output logic [0:7]  err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPND2 = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cmd_reg, cmd_next;
  logic [31:0] op1_reg, op1_next;
  logic [31:0] op2_reg, op2_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  resp_reg, resp_next;
  logic [31:0] data_reg, data_next;

  logic [1:0]  res_code;
  logic [31:0] res_data;
  logic [32:0] sum;

  // Result of the latched request; only sampled on the edge that enters RESP.
  always_comb begin
    res_code = RESP_ERR;
    res_data = '0;
    sum      = {1'b0, op1_reg} + {1'b0, op2_reg};
    case (cmd_reg)
      CMD_ADD: begin
        if (!sum[32]) begin
          res_code = RESP_OK;
          res_data = sum[31:0];
        end
      end
      CMD_SUB: begin
        if (op2_reg <= op1_reg) begin
          res_code = RESP_OK;
          res_data = op1_reg - op2_reg;
        end
      end
      CMD_SHL: begin
        res_code = RESP_OK;
        res_data = op1_reg << op2_reg[4:0];
      end
      CMD_SHR: begin
        res_code = RESP_OK;
        res_data = op1_reg >> op2_reg[4:0];
      end
      default: begin
        res_code = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  // Next-state and datapath updates. The counter is loaded with LATENCY-1 on
  // the operand-2 edge and EXEC leaves on the edge where it reads zero, so the
  // response registers load exactly LATENCY edges after operand-2 capture.
  // LATENCY=1 therefore spends a single EXEC cycle with the counter already at
  // zero, which keeps the edge count exact at the low end of the range.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    op1_next   = op1_reg;
    op2_next   = op2_reg;
    cnt_next   = cnt_reg;
    resp_next  = resp_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cmd_next   = req_cmd_in;
          op1_next   = req_data_in;
          state_next = OPND2;
        end
      end
      OPND2: begin
        // Command bus is deliberately ignored here.
        op2_next   = req_data_in;
        cnt_next   = CNT_LOAD;
        state_next = EXEC;
      end
      EXEC: begin
        if (cnt_reg == 4'd0) begin
          resp_next  = res_code;
          data_next  = res_data;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        resp_next  = 2'd0;
        data_next  = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cmd_reg   <= '0;
      op1_reg   <= '0;
      op2_reg   <= '0;
      cnt_reg   <= '0;
      resp_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      op1_reg   <= op1_next;
      op2_reg   <= op2_next;
      cnt_reg   <= cnt_next;
      resp_reg  <= resp_next;
      data_reg  <= data_next;
    end
  end

  assign out_resp = resp_reg;
  assign out_data = data_reg;
  assign busy     = (state_reg != IDLE);

`ifdef CALC_ERR_COUNT_EN
  logic [7:0] err_reg;

  // Counts on the same edge that loads an error response; holds at 8'hFF.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      err_reg <= '0;
    end else if (state_reg == EXEC && cnt_reg == 4'd0 && res_code == RESP_ERR
                 && err_reg != 8'hFF) begin
      err_reg <= err_reg + 8'd1;
    end
  end

  assign err_count = err_reg;
`endif

endmodule

// File: tb/tb_calc_port_responder.sv
module tb_calc_port_responder;

  localparam int LAT = 3;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:3]  req_cmd_in = '0;
  logic [0:31] req_data_in = '0;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;
`ifdef CALC_ERR_COUNT_EN
  logic [0:7]  err_count;
`endif

  calc_port_responder #(.LATENCY(LAT)) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .busy       (busy)
`ifdef CALC_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_err = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  // Monitor: every cycle with a response pops the scoreboard.
  always @(negedge c_clk) begin
    if (reset) begin
      if (out_resp != 2'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp=%0d data=%h, required no response", out_resp, out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (out_resp !== e.resp || out_data !== e.data) begin
            errors++;
            $display("FAIL %s: got resp=%0d data=%h, required resp=%0d data=%h",
                     e.name, out_resp, out_data, e.resp, e.data);
          end else begin
            $display("resp %s: resp=%0d data=%h cycle=%0d", e.name, out_resp, out_data, cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_latency: got cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
          end
`ifdef CALC_ERR_COUNT_EN
          if (e.resp == 2'd2 && exp_err < 255) exp_err++;
          checks++;
          if (err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL %s_err_count: got %0d, required %0d", e.name, err_count, exp_err);
          end
`endif
        end
      end else if (out_data != 32'd0) begin
        checks++;
        errors++;
        $display("FAIL data_without_resp: got data=%h, required 0", out_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) break;
      @(negedge c_clk);
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%b, required 0 within 40 cycles", busy);
    end
  endtask

  // Issues a request at negedges; returns at the negedge after op2 capture.
  task automatic do_req(input string name, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] cmd2, input bit expect_resp,
                        input logic [1:0] er, input logic [31:0] ed);
    wait_idle();
    req_cmd_in  = cmd;
    req_data_in = a;
    @(negedge c_clk);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    req_cmd_in  = cmd2;
    req_data_in = b;
    @(negedge c_clk);
    if (expect_resp) exp_q.push_back('{er, ed, cyc + LAT, name});
    req_cmd_in  = '0;
    req_data_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_resp", 32'(out_resp), 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);

    do_req("add_carry_bit3", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 4'd0, 1, 2'd1, 32'h2000_0000);
    do_req("add_overflow",   4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 1, 2'd2, 32'h0);
    do_req("sub_underflow",  4'd2, 32'h0000_0001, 32'h0000_000F, 4'd0, 1, 2'd2, 32'h0);
    do_req("sub_ok_cmd_ign", 4'd2, 32'h0000_000F, 32'h0000_0001, 4'd6, 1, 2'd1, 32'h0000_000E);
    do_req("sub_equal",      4'd2, 32'h0000_0005, 32'h0000_0005, 4'd0, 1, 2'd1, 32'h0);
    do_req("shl_low5",       4'd5, 32'h0000_0001, 32'hFFFF_FFE4, 4'd0, 1, 2'd1, 32'h0000_0010);
    do_req("shr_31",         4'd6, 32'h8000_0000, 32'h0000_001F, 4'd0, 1, 2'd1, 32'h0000_0001);
    do_req("shl_lost_bits",  4'd5, 32'hF000_000F, 32'h0000_0004, 4'd0, 1, 2'd1, 32'h0000_00F0);
    do_req("invalid_cmd3",   4'd3, 32'h0000_0001, 32'h0000_0001, 4'd0, 1, 2'd2, 32'h0);
    do_req("invalid_cmd4",   4'd4, 32'h0000_0001, 32'h0000_0001, 4'd0, 1, 2'd2, 32'h0);

    // Busy drop: a command in EXEC and one at the edge leaving RESP are both lost.
    do_req("busy_drop_orig", 4'd1, 32'h0000_0002, 32'h0000_0003, 4'd0, 1, 2'd1, 32'h0000_0005);
    req_cmd_in  = 4'd1;
    req_data_in = 32'h5;
    @(negedge c_clk);
    req_cmd_in  = '0;
    req_data_in = '0;
    @(negedge c_clk);
    @(negedge c_clk);
    chk("busy_in_resp", 32'(busy), 32'd1);
    req_cmd_in  = 4'd1;
    req_data_in = 32'h7;
    @(negedge c_clk);
    chk("busy_falls", 32'(busy), 32'd0);
    req_cmd_in  = '0;
    req_data_in = '0;
    @(negedge c_clk);
    chk("resp_exit_cmd_dropped", 32'(busy), 32'd0);
    repeat (6) @(negedge c_clk);

    // Reset during EXEC aborts the request.
    do_req("abort_req", 4'd1, 32'h0000_0004, 32'h0000_0004, 4'd0, 0, 2'd0, 32'h0);
    @(negedge c_clk);
    #2;
    reset   = 1'b0;
    exp_err = 0;
    #1;
    chk("abort_resp", 32'(out_resp), 32'd0);
    chk("abort_data", out_data, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge c_clk);
    reset = 1'b1;
    repeat (8) @(negedge c_clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    do_req("add_zero", 4'd1, 32'h0, 32'h0, 4'd0, 1, 2'd1, 32'h0);
    do_req("after_reset_inv", 4'd9, 32'h1, 32'h2, 4'd0, 1, 2'd2, 32'h0);

    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge c_clk);
    end
    repeat (3) @(negedge c_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
